// File: rtl/conv_pkg.sv
// conv_pkg: definitions of the rate-1/2, K=3 (7,5 octal) convolutional code
// shared by the transmit-side encoder and the receive-side Viterbi decoder,
// so that both ends always agree on the generator polynomials.
//   G0, G1          generator taps applied to {u, p1, p0}
//   K, N_STATES     constraint length and trellis size
//   expected_pair   code pair {c1, c0} emitted for input u from state {p1, p0}
//   pair_distance   Hamming distance between two code pairs (0..2)
package conv_pkg;

  localparam logic [2:0] G0       = 3'b111;
  localparam logic [2:0] G1       = 3'b101;
  localparam int         K        = 3;
  localparam int         N_STATES = 4;

  function automatic logic [1:0] expected_pair(input logic u, input logic p1, input logic p0);
    logic [2:0] taps;
    taps = {u, p1, p0};
    return {^(G0 & taps), ^(G1 & taps)};
  endfunction

  function automatic logic [1:0] pair_distance(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

endpackage

// File: rtl/acs_unit.sv
// acs_unit: add-compare-select for one trellis state {u, p1}.
//   pm_a     path metric of predecessor {p1, 0}
//   pm_b     path metric of predecessor {p1, 1}
//   conv_in  received code pair {g0 bit, g1 bit}
//   u, p1    the state this unit serves
//   pm_new   winning candidate metric, one bit wider than stored metrics,
//            not yet normalised
//   dec      chosen predecessor's p0 bit (0 on a tie)
module acs_unit
  import conv_pkg::*;
#(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      conv_in,
  input  logic            u,
  input  logic            p1,
  output logic [PM_W:0]   pm_new,
  output logic            dec
);

  localparam int CW = PM_W + 1;

  logic [1:0]    bm_a;
  logic [1:0]    bm_b;
  logic [CW-1:0] cand_a;
  logic [CW-1:0] cand_b;

  assign bm_a   = pair_distance(conv_in, expected_pair(u, p1, 1'b0));
  assign bm_b   = pair_distance(conv_in, expected_pair(u, p1, 1'b1));
  assign cand_a = {1'b0, pm_a} + CW'(bm_a);
  assign cand_b = {1'b0, pm_b} + CW'(bm_b);

  // strict compare so that ties resolve to the p0 = 0 predecessor
  assign dec    = (cand_b < cand_a);
  assign pm_new = dec ? cand_b : cand_a;

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the (7,5) K=3 code,
// register-exchange survivors, four path metrics normalised every step.
//   clk        bit-rate clock
//   reset      asynchronous, active-low; clears all state
//   conv_in    received code pair, [1] = g0 bit, [0] = g1 bit
//   in_valid   conv_in accepted on the rising clk edge when high
//   dec_out    decoded bit, delayed TB_DEPTH accepted pairs
//   out_valid  dec_out valid this cycle (in_valid high and survivors full)
module viterbi_decoder
  import conv_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] conv_in,
  input  logic       in_valid,
  output logic       dec_out,
  output logic       out_valid
);

  localparam int              CW      = PM_W + 1;
  localparam int              CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
  // non-zero start metrics make state 00 the only credible origin
  localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(1) << (PM_W - 1);

  logic [PM_W-1:0]                     pm_q [N_STATES];
  logic [PM_W-1:0]                     pm_norm [N_STATES];
  logic [N_STATES-1:0][CW-1:0]         cand;
  logic [N_STATES-1:0]                 dec;
  logic [CW-1:0]                       cand_min;
  logic [N_STATES-1:0][TB_DEPTH-1:0]   sv_q;
  logic [N_STATES-1:0][TB_DEPTH-1:0]   sv_pred;
  logic [N_STATES-1:0][TB_DEPTH-1:0]   sv_d;
  logic [CNT_W-1:0]                    cnt_q;
  logic                                dec_hold_q;
  logic [1:0]                          best;
  logic [PM_W-1:0]                     best_pm;
  logic                                dec_live;

  for (genvar s = 0; s < N_STATES; s++) begin : g_state
    localparam logic [1:0] S = 2'(s);

    acs_unit #(.PM_W(PM_W)) u_acs (
      .pm_a    (pm_q[{S[0], 1'b0}]),
      .pm_b    (pm_q[{S[0], 1'b1}]),
      .conv_in (conv_in),
      .u       (S[1]),
      .p1      (S[0]),
      .pm_new  (cand[s]),
      .dec     (dec[s])
    );

    assign sv_pred[s] = dec[s] ? sv_q[{S[0], 1'b1}] : sv_q[{S[0], 1'b0}];
    assign sv_d[s]    = {sv_pred[s][TB_DEPTH-2:0], S[1]};
  end

  always_comb begin
    cand_min = cand[0];
    for (int s = 1; s < N_STATES; s++) begin
      if (cand[s] < cand_min) cand_min = cand[s];
    end
    for (int s = 0; s < N_STATES; s++) begin
      pm_norm[s] = PM_W'(cand[s] - cand_min);
    end
  end

  // lowest index wins on equal metrics
  always_comb begin
    best    = '0;
    best_pm = pm_q[0];
    for (int s = 1; s < N_STATES; s++) begin
      if (pm_q[s] < best_pm) begin
        best    = 2'(s);
        best_pm = pm_q[s];
      end
    end
  end

  assign dec_live  = sv_q[best][TB_DEPTH-1];
  assign dec_out   = in_valid ? dec_live : dec_hold_q;
  assign out_valid = in_valid && (cnt_q == CNT_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pm_q[0] <= '0;
      for (int s = 1; s < N_STATES; s++) pm_q[s] <= PM_INIT;
      sv_q       <= '0;
      cnt_q      <= '0;
      dec_hold_q <= 1'b0;
    end else if (in_valid) begin
      for (int s = 0; s < N_STATES; s++) pm_q[s] <= pm_norm[s];
      sv_q       <= sv_d;
      dec_hold_q <= dec_live;
      if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 4;

  typedef struct packed {
    logic val;
    logic care;
    logic tol;
    int   idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] conv_in = 2'b00;
  logic       in_valid = 1'b0;
  logic       dec_out;
  logic       out_valid;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         fill = 0;
  int         pops = 0;
  bit         hold_known = 1'b0;
  logic       hold_val = 1'b0;
  int         burst_err = 0;
  int         burst_first = -1;
  int         burst_last = -1;
  logic [1:0] st = 2'b00;
  logic [6:0] lfsr = 7'h5A;
  int         idx = 0;

  exp_t            m_e;
  bit              m_exp_ov;
  logic [PM_W-1:0] m_min;

  always #5 clk = ~clk;

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .conv_in   (conv_in),
    .in_valid  (in_valid),
    .dec_out   (dec_out),
    .out_valid (out_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dec_out", 32'(dec_out), 32'd0);
      fill = 0;
      hold_known = 1'b0;
    end else begin
      m_exp_ov = in_valid && (fill == TB_DEPTH);
      chk("out_valid", 32'(out_valid), 32'(m_exp_ov));
      m_min = dut.pm_q[0];
      for (int s = 1; s < 4; s++) if (dut.pm_q[s] < m_min) m_min = dut.pm_q[s];
      chk("pm_min", 32'(m_min), 32'd0);
      if (!in_valid && hold_known) chk("dec_hold", 32'(dec_out), 32'(hold_val));
      if (m_exp_ov) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_empty: got out_valid with no expected bit at %0t", $time);
          hold_known = 1'b0;
        end else begin
          m_e = q.pop_front();
          pops++;
          if (m_e.care && m_e.tol) begin
            if (dec_out !== m_e.val) begin
              burst_err++;
              if (burst_first < 0) burst_first = m_e.idx;
              burst_last = m_e.idx;
            end
          end else if (m_e.care) begin
            chk("dec_out", 32'(dec_out), 32'(m_e.val));
          end
          hold_known = m_e.care && !m_e.tol;
          hold_val   = m_e.val;
        end
      end else if (in_valid) begin
        hold_known = 1'b0;
      end
      if (in_valid && fill < TB_DEPTH) fill++;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    q.delete();
    st = 2'b00;
    idx = 0;
    repeat (2) @(posedge clk);
    #1;
    pops = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_drive(input logic [1:0] pair, input logic u, input logic care, input logic tol);
    exp_t e;
    e.val = u;
    e.care = care;
    e.tol = tol;
    e.idx = idx;
    q.push_back(e);
    idx++;
    conv_in = pair;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bit(input logic u, input logic [1:0] flip, input logic tol);
    logic [1:0] pair;
    pair = enc(u, st) ^ flip;
    st = {u, st[1]};
    push_drive(pair, u, 1'b1, tol);
  endtask

  task automatic next_u(output logic u);
    lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    u = lfsr[0];
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] hp [7];
    logic [6:0] hu;
    logic       u;
    logic [1:0] fl;

    hp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
    hu = 7'b1011000;

    // error-free stream, starting with the hand-encoded 1011000 vector
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push_drive(hp[i], hu[6-i], 1'b1, 1'b0);
    end
    st = 2'b00;
    for (int i = 7; i < 200; i++) begin
      next_u(u);
      send_bit(u, 2'b00, 1'b0);
    end
    idle(3);
    chk("pops_clean", 32'(pops), 32'd184);

    // single bit error in every 10th pair
    do_reset();
    for (int i = 0; i < 200; i++) begin
      next_u(u);
      fl = (i % 10 == 9) ? (((i / 10) % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
      send_bit(u, fl, 1'b0);
    end
    idle(3);
    chk("pops_single", 32'(pops), 32'd184);

    // three fully inverted pairs; errors tolerated only near the burst
    do_reset();
    for (int i = 0; i < 200; i++) begin
      next_u(u);
      fl = (i >= 100 && i <= 102) ? 2'b11 : 2'b00;
      send_bit(u, fl, (i >= 80 && i <= 120) ? 1'b1 : 1'b0);
    end
    idle(3);
    chk("pops_burst", 32'(pops), 32'd184);
    chk("burst_span", (burst_err == 0) ? 32'd1 : 32'((burst_last - burst_first + 1) <= 16), 32'd1);

    // random gaps in in_valid
    do_reset();
    for (int i = 0; i < 200; i++) begin
      next_u(u);
      send_bit(u, 2'b00, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end
    idle(3);
    chk("pops_gaps", 32'(pops), 32'd184);

    // reset mid-stream at pair 57, then refill from state 00
    do_reset();
    for (int i = 0; i < 57; i++) begin
      next_u(u);
      send_bit(u, 2'b00, 1'b0);
    end
    chk("pops_pre_reset", 32'(pops), 32'd41);
    do_reset();
    for (int i = 0; i < 100; i++) begin
      next_u(u);
      send_bit(u, 2'b00, 1'b0);
    end
    idle(3);
    chk("pops_post_reset", 32'(pops), 32'd84);

    // all-ones received pairs; metric bound exercised by the monitor
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      push_drive(2'b11, 1'b0, 1'b0, 1'b0);
    end
    idle(3);
    chk("pops_ones", 32'(pops), 32'd984);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
